// File: rtl/imem_program_loader.sv
// Boot-time loader: parses a framed byte stream (count header, big-endian words,
// XOR checksum), writes words into instruction memory and releases the core on a match.
module imem_program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              cpu_run_o,
  output logic              load_done_o,
  output logic              load_error_o
);

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

  state_e              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [31:0]         asm_q, asm_d;
  logic [31:0]         csum_q, csum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                run_q, run_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;

  logic                xfer_s;
  logic [31:0]         word_s;
  logic [16:0]         hdr_n_s;
  logic [16:0]         words_next_s;

  function automatic logic [31:0] csum_fold(input logic [31:0] acc, input logic [31:0] word);
    return acc ^ word;
  endfunction

  assign xfer_s       = in_valid_i && ready_q;
  assign word_s       = {asm_q[23:0], in_data_i};
  assign hdr_n_s      = {1'b0, count_q[15:8], in_data_i};
  assign words_next_s = 17'(word_cnt_q) + 17'd1;

  // Next-state and output decode for the frame parser.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    run_d      = run_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_HDR0: begin
        if (xfer_s) begin
          count_d[15:8] = in_data_i;
          state_d       = S_HDR1;
        end else begin
          state_d = S_HDR0;
        end
      end
      S_HDR1: begin
        if (xfer_s) begin
          count_d = hdr_n_s[15:0];
          if (hdr_n_s > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (hdr_n_s == 17'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_HDR1;
        end
      end
      S_DATA: begin
        if (xfer_s) begin
          asm_d      = word_s;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wdata_d    = word_s;
            csum_d     = csum_fold(csum_q, word_s);
            word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
            // The word counter is one wider than the address so N = 2^ADDR_W terminates.
            if (words_next_s == {1'b0, count_q}) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_CSUM: begin
        if (xfer_s) begin
          asm_d      = word_s;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (word_s == csum_q) begin
              state_d = S_DONE;
              run_d   = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end
          end else begin
            state_d = S_CSUM;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
        err_d   = 1'b1;
        run_d   = 1'b0;
        done_d  = 1'b0;
      end
    endcase
    ready_d = (state_d != S_DONE);
  end

  // State and output registers; reset wins over a concurrent byte transfer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_HDR0;
      count_q    <= 16'd0;
      byte_cnt_q <= 2'd0;
      word_cnt_q <= '0;
      asm_q      <= 32'd0;
      csum_q     <= 32'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
      csum_q     <= csum_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      run_q      <= run_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign in_ready_o   = ready_q;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_run_o    = run_q;
  assign load_done_o  = done_q;
  assign load_error_o = err_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed frames plus randomized
// frames compared against a frame-level reference model.
module tb_imem_program_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'd0;
  logic              in_ready, imem_we, cpu_run, load_done, load_error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  imem_program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .imem_we_o(imem_we), .imem_addr_o(imem_addr),
    .imem_wdata_o(imem_wdata), .cpu_run_o(cpu_run), .load_done_o(load_done),
    .load_error_o(load_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_cyc = 0;
  logic [31:0] words [0:299];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          acc_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: one entry per cycle that imem_we is high.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_xor(input int n);
    logic [31:0] x = 32'd0;
    for (int i = 0; i < n; i++) x = x ^ words[i];
    return x;
  endfunction

  task automatic clear_writes();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
  endtask

  task automatic do_reset(input bit hold_valid);
    in_valid = hold_valid;
    in_data  = 8'hFF;
    reset    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    clear_writes();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int waited = 0;
    while (int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic send_frame(input int n, input logic [31:0] csum, input int gap_pct, input bit skip_last);
    acc_cyc_q.delete();
    send_byte(n[15:8], gap_pct);
    send_byte(n[7:0], gap_pct);
    for (int i = 0; i < n; i++) begin
      for (int k = 3; k >= 0; k--) begin
        send_byte(words[i][8*k +: 8], gap_pct);
        if (k == 0) acc_cyc_q.push_back(last_cyc);
      end
    end
    for (int k = 3; k >= (skip_last ? 1 : 0); k--) send_byte(csum[8*k +: 8], gap_pct);
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    n_tests++;
    if ({imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error, in_ready} !== {1'b0, 8'd0, 32'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_state we=%b addr=%0d wd=%h run=%b done=%b err=%b rdy=%b want 0,0,0,0,0,0,1",
               imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error, in_ready);
    end
  endtask

  task automatic test_good_frame();
    do_reset(1'b0);
    words[0] = 32'h20080005; words[1] = 32'h01095020;
    send_frame(2, 32'h21015025, 0, 1'b1);
    n_tests++;
    if (cpu_run !== 1'b0) begin n_fail++; $display("FAIL good_early_run got %b want 0", cpu_run); end
    send_byte(8'h25, 0);
    n_tests++;
    if ({cpu_run, load_done, load_error, in_ready} !== 4'b1100) begin
      n_fail++; $display("FAIL good_verdict run/done/err/rdy got %b%b%b%b want 1100", cpu_run, load_done, load_error, in_ready);
    end
    n_tests++;
    if (wr_addr_q.size() != 2) begin n_fail++; $display("FAIL good_wr_count got %0d want 2", wr_addr_q.size()); end
    for (int i = 0; i < wr_addr_q.size() && i < 2; i++) begin
      n_tests++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== words[i] || wr_cyc_q[i] != acc_cyc_q[i]) begin
        n_fail++; $display("FAIL good_wr%0d got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                           i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], i, words[i], acc_cyc_q[i]);
      end
    end
    // Bytes offered in DONE must be refused and change nothing.
    in_valid = 1'b1; in_data = 8'hAB;
    repeat (4) @(negedge clk);
    n_tests++;
    if ({in_ready, cpu_run, load_done, load_error} !== 4'b0110 || wr_addr_q.size() != 2) begin
      n_fail++; $display("FAIL done_ignore rdy/run/done/err got %b%b%b%b writes=%0d want 0110 writes=2",
                         in_ready, cpu_run, load_done, load_error, wr_addr_q.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_bad_csum();
    do_reset(1'b0);
    words[0] = 32'h20080005; words[1] = 32'h01095020;
    send_frame(2, 32'h21015024, 0, 1'b0);
    n_tests++;
    if ({cpu_run, load_done, load_error, in_ready} !== 4'b0011) begin
      n_fail++; $display("FAIL bad_verdict run/done/err/rdy got %b%b%b%b want 0011", cpu_run, load_done, load_error, in_ready);
    end
    n_tests++;
    if (wr_addr_q.size() != 2 || wr_data_q[0] !== 32'h20080005 || wr_data_q[1] !== 32'h01095020) begin
      n_fail++; $display("FAIL bad_writes got count=%0d want 2 with frame data", wr_addr_q.size());
    end
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    n_tests++;
    if (wr_addr_q.size() != 2 || {cpu_run, load_error, in_ready} !== 3'b011) begin
      n_fail++; $display("FAIL err_discard writes=%0d run/err/rdy=%b%b%b want 2, 011", wr_addr_q.size(), cpu_run, load_error, in_ready);
    end
  endtask

  task automatic test_zero_len();
    do_reset(1'b0);
    send_frame(0, 32'h0, 0, 1'b0);
    n_tests++;
    if ({cpu_run, load_done, load_error} !== 3'b110 || wr_addr_q.size() != 0) begin
      n_fail++; $display("FAIL zero_len run/done/err=%b%b%b writes=%0d want 110 writes=0", cpu_run, load_done, load_error, wr_addr_q.size());
    end
  endtask

  task automatic test_oversize();
    do_reset(1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    n_tests++;
    if ({load_error, in_ready, cpu_run} !== 3'b110) begin
      n_fail++; $display("FAIL oversize_hdr err/rdy/run got %b%b%b want 110", load_error, in_ready, cpu_run);
    end
    for (int i = 0; i < 12; i++) send_byte(8'($urandom), 0);
    n_tests++;
    if (wr_addr_q.size() != 0 || {load_error, in_ready, load_done} !== 3'b110) begin
      n_fail++; $display("FAIL oversize_data writes=%0d err/rdy/done=%b%b%b want 0, 110", wr_addr_q.size(), load_error, in_ready, load_done);
    end
  endtask

  // Shared by several scenarios: random frame, gaps and corruption, checked against the model.
  task automatic test_random_frame(input string name, input int n, input int gap_pct, input bit corrupt);
    logic [31:0] csum;
    bit exp_ok;
    do_reset(1'b0);
    for (int i = 0; i < n; i++) words[i] = $urandom;
    csum   = ref_xor(n) ^ (corrupt ? ($urandom | 32'h1) : 32'h0);
    exp_ok = !corrupt;
    send_frame(n, csum, gap_pct, 1'b0);
    n_tests++;
    if (wr_addr_q.size() != n) begin n_fail++; $display("FAIL %s_wr_count got %0d want %0d", name, wr_addr_q.size(), n); end
    for (int i = 0; i < wr_addr_q.size() && i < n; i++) begin
      n_tests++;
      if (wr_addr_q[i] != i || wr_data_q[i] !== words[i] || wr_cyc_q[i] != acc_cyc_q[i]) begin
        n_fail++; $display("FAIL %s_wr%0d got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                           name, i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], i, words[i], acc_cyc_q[i]);
      end
    end
    n_tests++;
    if ({cpu_run, load_done, load_error, in_ready} !== (exp_ok ? 4'b1100 : 4'b0011)) begin
      n_fail++; $display("FAIL %s_verdict run/done/err/rdy got %b%b%b%b want %s",
                         name, cpu_run, load_done, load_error, in_ready, exp_ok ? "1100" : "0011");
    end
  endtask

  task automatic test_gaps();
    do_reset(1'b0);
    words[0] = 32'h20080005; words[1] = 32'h01095020;
    send_frame(2, 32'h21015025, 50, 1'b0);
    n_tests++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] != 0 || wr_data_q[0] !== 32'h20080005 ||
        wr_addr_q[1] != 1 || wr_data_q[1] !== 32'h01095020 ||
        wr_cyc_q[0] != acc_cyc_q[0] || wr_cyc_q[1] != acc_cyc_q[1]) begin
      n_fail++; $display("FAIL gaps_writes count=%0d want 2 at addr 0,1 with frame data after 4th bytes", wr_addr_q.size());
    end
    n_tests++;
    if ({cpu_run, load_done, load_error} !== 3'b110) begin
      n_fail++; $display("FAIL gaps_verdict run/done/err got %b%b%b want 110", cpu_run, load_done, load_error);
    end
  endtask

  task automatic test_reset_midload();
    do_reset(1'b0);
    words[0] = 32'h20080005; words[1] = 32'h01095020;
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    for (int k = 3; k >= 0; k--) send_byte(words[0][8*k +: 8], 0);
    send_byte(words[1][31:24], 0);
    do_reset(1'b1);
    n_tests++;
    if ({imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error, in_ready} !== {1'b0, 8'd0, 32'd0, 4'b0001}) begin
      n_fail++; $display("FAIL midload_reset we=%b addr=%0d wd=%h run/done/err/rdy=%b%b%b%b want 0,0,0,0001",
                         imem_we, imem_addr, imem_wdata, cpu_run, load_done, load_error, in_ready);
    end
    send_frame(2, 32'h21015025, 0, 1'b0);
    n_tests++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] != 0 || wr_data_q[0] !== 32'h20080005 ||
        wr_addr_q[1] != 1 || wr_data_q[1] !== 32'h01095020 || {cpu_run, load_done, load_error} !== 3'b110) begin
      n_fail++; $display("FAIL midload_reload writes=%0d run/done/err=%b%b%b want 2 writes at 0,1 and 110",
                         wr_addr_q.size(), cpu_run, load_done, load_error);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_zero_len();
    test_oversize();
    test_gaps();
    test_reset_midload();
    test_random_frame("full", 256, 0, 1'b0);
    for (int t = 0; t < 8; t++)
      test_random_frame("rand", int'($urandom_range(0, 6)), int'($urandom_range(0, 60)), ($urandom_range(0, 3) == 0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_program_loader.md
# imem_program_loader

Boot-time program loader on the instruction-fetch side of the single-cycle MIPS core. Accepts a framed byte stream (length header, big-endian instruction words, XOR checksum), assembles 32-bit words and writes them into the instruction memory's write port at consecutive word addresses. Once the checksum verifies, it releases the core through `cpu_run`; the core's PC counter and register file stay held while `cpu_run` is low.

## Interface

- `ADDR_W`, 8, instruction memory word-address width; capacity is 2^ADDR_W words.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle. A byte transfers on a rising edge with `in_valid && in_ready`.
- `imem_we`  out  1  instruction memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address, 0-based.
- `imem_wdata`  out  32  assembled instruction word.
- `cpu_run`  out  1  level; releases the core.
- `load_done`  out  1  level; load finished and checksum matched.
- `load_error`  out  1  level; load aborted.

## Operation

- Frame format:
  - 2 bytes of word count N, big-endian (16 bits).
  - 4·N data bytes; each word is sent MSB first.
  - 4 checksum bytes, MSB first. The checksum equals the XOR of all N words (0 when N=0).
- States: HDR0, HDR1, DATA, CSUM, DONE, ERR.
  - HDR0: accept count high byte, go to HDR1.
  - HDR1: accept count low byte. Next state:
    - ERR if N > 2^ADDR_W.
    - CSUM if N = 0.
    - DATA otherwise.
  - DATA:
    - Shift bytes into a 32-bit assembly register; a 2-bit byte counter tracks position.
    - On the 4th byte, issue a write and XOR the word into the running checksum.
    - The word counter (ADDR_W+1 bits) increments per word. After word N-1, go to CSUM.
  - CSUM: assemble 4 bytes. Next state is DONE if they equal the running XOR, else ERR.
  - DONE: `cpu_run`=1, `load_done`=1, `in_ready`=0. Terminal until `reset`.
  - ERR: `load_error`=1, `cpu_run`=0, `in_ready`=1. Incoming bytes are accepted and discarded. Terminal until `reset`.
- `in_ready` = 1 in HDR0, HDR1, DATA, CSUM, ERR; 0 in DONE. There is no internal backpressure; a word write never stalls the stream.
- Gaps: `in_valid` low holds all counters and assembly state. No timeout.
- Bytes arriving in DONE are not accepted and have no effect.
- The core never runs on a partially loaded or unverified image.

## Timing

- Reset values:
  - State HDR0.
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_run`=0, `load_done`=0, `load_error`=0.
  - Byte counter, word counter and running checksum all 0.
  - `in_ready`=1 from the first cycle after `reset` deasserts.
- Write latency:
  - `imem_we` is high exactly one cycle: the cycle after the edge that accepted a word's 4th byte.
  - `imem_addr` and `imem_wdata` are valid in that same cycle.
  - Back-to-back bytes therefore give a write every 4 cycles.
- `imem_addr` and `imem_wdata` hold their last values between writes.
- Verdict:
  - DONE or ERR is entered on the edge accepting the 4th checksum byte.
  - `cpu_run`, `load_done` and `load_error` are registered and go high in the following cycle.
- Oversize N: ERR is entered on the edge accepting the count low byte; no write is issued.
- N = 2^ADDR_W is legal; the last write goes to address 2^ADDR_W-1.
- Reset mid-load: everything returns to HDR0 values on the next edge. Memory words already written are left as is, and the next frame overwrites them.
- `reset` has priority over a simultaneous byte transfer.

## Test plan

- N=2, words 0x20080005, 0x01095020, checksum 0x21015025, sent back-to-back:
  - two `imem_we` pulses: (addr 0, 0x20080005) then (addr 1, 0x01095020);
  - `cpu_run`=`load_done`=1 one cycle after the final checksum byte.
- Same frame with checksum 0x21015024:
  - both writes occur;
  - `load_error`=1 and `cpu_run` stays 0;
  - further bytes are accepted (`in_ready`=1) with no writes.
- N=0, checksum 0x00000000 → DONE with no `imem_we`.
- ADDR_W=8, header 0x0101 → ERR right after header; no writes; `in_ready` stays 1.
- Same 2-word frame with `in_valid` low on random cycles (about 50%) → identical write sequence and verdict; `imem_we` only after complete words.
- `reset` pulse after 5 data bytes, then the full 2-word frame → counters restart; writes at addr 0 and 1 with the correct data; DONE reached.
